// File: rtl/issue_scheduler_pkg.sv
// ============================================================================
// Module : issue_scheduler_pkg
// Brief  : Shared types, sizes and the operand-resolution helper for issue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package issue_scheduler_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_TAG_W  = 4;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_BR  = 2'd2
    } fu_class_e;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic                 busy;
        logic                 re_busy;
        logic [ROB_TAG_W-1:0] rob_tag;
    } register_status_s;

    typedef struct packed {
        logic must_wait;
        logic in_rob;
    } operand_res_s;

    // A CDB broadcast of the producing tag in the lookup cycle turns a
    // pending operand into one that can be read from the ROB.
    function automatic operand_res_s resolve_operand(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] addr,
        input register_status_s      st,
        input logic                  cdb_valid,
        input logic [ROB_TAG_W-1:0]  cdb_tag
    );
        operand_res_s res;
        logic         hit;
        logic         live;
        hit           = cdb_valid & (cdb_tag == st.rob_tag);
        live          = use_src & (addr != '0) & st.busy;
        res.must_wait = live & st.re_busy & ~hit;
        res.in_rob    = live & ~res.must_wait;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rob_tag_allocator.sv
// ============================================================================
// Module : rob_tag_allocator
// Brief  : Circular ROB tag pool with in-order free, flush and sticky error.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_tag_allocator #(
    parameter int ROB_DEPTH = 16,
    localparam int c_tag_w  = $clog2(ROB_DEPTH),
    localparam int c_cnt_w  = c_tag_w + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               alloc_i,
    input  logic               commit_valid_i,
    input  logic [c_tag_w-1:0] commit_rob_tag_i,
    input  logic               commit_ignore_i,
    output logic [c_tag_w-1:0] tail_o,
    output logic [c_cnt_w-1:0] count_o,
    output logic               full_o,
    output logic               err_o
);

    logic [c_tag_w-1:0] r_head;
    logic [c_tag_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_err;

    logic w_commit_req;
    logic w_commit_bad;
    logic w_commit_ok;

    // Commits are only meaningful against live entries; a flush wipes them.
    assign w_commit_req = commit_valid_i & ~commit_ignore_i & ~flush_i;
    assign w_commit_bad = w_commit_req & ((r_count == '0) | (commit_rob_tag_i != r_head));
    assign w_commit_ok  = w_commit_req & ~w_commit_bad;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_commit_bad) begin
                r_err <= 1'b1;
            end
            if (flush_i) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (alloc_i) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_commit_ok) begin
                    r_head <= r_head + 1'b1;
                end
                r_count <= r_count + c_cnt_w'(alloc_i) - c_cnt_w'(w_commit_ok);
            end
        end
    end

    assign tail_o  = r_tail;
    assign count_o = r_count;
    assign full_o  = (r_count == c_cnt_w'(ROB_DEPTH));
    assign err_o   = r_err;

endmodule

`default_nettype wire

// File: rtl/issue_scheduler.sv
// ============================================================================
// Module : issue_scheduler
// Brief  : In-order issue stage: handshake, RS check, tag alloc, recovery.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int ROB_DEPTH    = 16,
    parameter int NUM_FU       = 3,
    parameter int DRAIN_CYCLES = 2,
    localparam int c_tag_w     = $clog2(ROB_DEPTH),
    localparam int c_drain_w   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               recover_en,
    input  logic               dec_valid_i,
    output logic               dec_ready_o,
    input  logic [4:0]         dec_rd_i,
    input  logic [4:0]         dec_rs1_i,
    input  logic [4:0]         dec_rs2_i,
    input  logic               dec_use_rs1_i,
    input  logic               dec_use_rs2_i,
    input  logic [1:0]         dec_fu_i,
    input  logic               dec_store_i,
    input  logic [NUM_FU-1:0]  rs_free_i,
    output logic [NUM_FU-1:0]  rs_dispatch_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    input  register_status_s   packed_rs1_i,
    input  register_status_s   packed_rs2_i,
    output logic               src1_wait_o,
    output logic               src2_wait_o,
    output logic               src1_in_rob_o,
    output logic               src2_in_rob_o,
    output logic [c_tag_w-1:0] src1_tag_o,
    output logic [c_tag_w-1:0] src2_tag_o,
    output logic               issue_valid_o,
    output logic [4:0]         issue_dst_o,
    output logic [c_tag_w-1:0] issue_rob_tag_o,
    output logic               issue_store_o,
    input  logic               cdb_valid_i,
    input  logic [c_tag_w-1:0] cdb_rob_tag_i,
    input  logic               commit_valid_i,
    input  logic [c_tag_w-1:0] commit_rob_tag_i,
    output logic [c_tag_w:0]   rob_count_o,
    output logic               err_o
);

    sched_state_e         r_state;
    logic [c_drain_w-1:0] r_drain_cnt;

    logic                 w_fu_free;
    logic [NUM_FU-1:0]    w_dispatch;
    logic                 w_ready;
    logic                 w_fire;
    logic [c_tag_w-1:0]   w_tail;
    logic [c_tag_w:0]     w_count;
    logic                 w_full;
    logic                 w_err;
    operand_res_s         w_src1;
    operand_res_s         w_src2;

    // FU classes beyond NUM_FU never match, so they can never be issued.
    always_comb begin
        w_fu_free  = 1'b0;
        w_dispatch = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (dec_fu_i == 2'(i)) begin
                w_fu_free     = rs_free_i[i];
                w_dispatch[i] = 1'b1;
            end
        end
    end

    assign w_ready = ~reset_i & (r_state == RUN) & ~recover_en & ~w_full & w_fu_free;
    assign w_fire  = w_ready & dec_valid_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
        end else if (recover_en) begin
            r_state     <= DRAIN;
            r_drain_cnt <= c_drain_w'(DRAIN_CYCLES - 1);
        end else if (r_state == DRAIN) begin
            if (r_drain_cnt == '0) begin
                r_state <= RUN;
            end else begin
                r_drain_cnt <= r_drain_cnt - 1'b1;
            end
        end
    end

    rob_tag_allocator #(
        .ROB_DEPTH (ROB_DEPTH)
    ) u_rob_tag_allocator (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .flush_i          (recover_en),
        .alloc_i          (w_fire),
        .commit_valid_i   (commit_valid_i),
        .commit_rob_tag_i (commit_rob_tag_i),
        .commit_ignore_i  (r_state == DRAIN),
        .tail_o           (w_tail),
        .count_o          (w_count),
        .full_o           (w_full),
        .err_o            (w_err)
    );

    assign w_src1 = resolve_operand(dec_use_rs1_i, dec_rs1_i, packed_rs1_i,
                                    cdb_valid_i, cdb_rob_tag_i);
    assign w_src2 = resolve_operand(dec_use_rs2_i, dec_rs2_i, packed_rs2_i,
                                    cdb_valid_i, cdb_rob_tag_i);

    assign dec_ready_o     = w_ready;
    assign issue_valid_o   = w_fire;
    assign rs_dispatch_o   = w_fire ? w_dispatch : '0;
    assign issue_dst_o     = w_fire ? dec_rd_i : '0;
    assign issue_rob_tag_o = w_fire ? w_tail : '0;
    assign issue_store_o   = w_fire & dec_store_i;

    // Everything visible is held at zero while reset is asserted.
    assign rs1_o         = reset_i ? '0 : dec_rs1_i;
    assign rs2_o         = reset_i ? '0 : dec_rs2_i;
    assign src1_wait_o   = ~reset_i & w_src1.must_wait;
    assign src2_wait_o   = ~reset_i & w_src2.must_wait;
    assign src1_in_rob_o = ~reset_i & w_src1.in_rob;
    assign src2_in_rob_o = ~reset_i & w_src2.in_rob;
    assign src1_tag_o    = reset_i ? '0 : packed_rs1_i.rob_tag;
    assign src2_tag_o    = reset_i ? '0 : packed_rs2_i.rob_tag;
    assign rob_count_o   = reset_i ? '0 : w_count;
    assign err_o         = ~reset_i & w_err;

endmodule

`default_nettype wire

// File: tb/tb_issue_scheduler.sv
// ============================================================================
// Module : tb_issue_scheduler
// Brief  : Self-checking bench for issue_scheduler with a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             recover_en;
    logic             dec_valid_i;
    logic             dec_ready_o;
    logic [4:0]       dec_rd_i, dec_rs1_i, dec_rs2_i;
    logic             dec_use_rs1_i, dec_use_rs2_i;
    logic [1:0]       dec_fu_i;
    logic             dec_store_i;
    logic [2:0]       rs_free_i;
    logic [2:0]       rs_dispatch_o;
    logic [4:0]       rs1_o, rs2_o;
    register_status_s packed_rs1_i, packed_rs2_i;
    logic             src1_wait_o, src2_wait_o, src1_in_rob_o, src2_in_rob_o;
    logic [3:0]       src1_tag_o, src2_tag_o;
    logic             issue_valid_o;
    logic [4:0]       issue_dst_o;
    logic [3:0]       issue_rob_tag_o;
    logic             issue_store_o;
    logic             cdb_valid_i;
    logic [3:0]       cdb_rob_tag_i;
    logic             commit_valid_i;
    logic [3:0]       commit_rob_tag_i;
    logic [4:0]       rob_count_o;
    logic             err_o;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding tags in age order, next tag, drain cycles left.
    int q_tags[$];
    int m_tail;
    int m_drain;
    bit m_err;

    issue_scheduler #(.ROB_DEPTH(16), .NUM_FU(3), .DRAIN_CYCLES(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .recover_en(recover_en),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rd_i(dec_rd_i), .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
        .dec_use_rs1_i(dec_use_rs1_i), .dec_use_rs2_i(dec_use_rs2_i),
        .dec_fu_i(dec_fu_i), .dec_store_i(dec_store_i),
        .rs_free_i(rs_free_i), .rs_dispatch_o(rs_dispatch_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o),
        .packed_rs1_i(packed_rs1_i), .packed_rs2_i(packed_rs2_i),
        .src1_wait_o(src1_wait_o), .src2_wait_o(src2_wait_o),
        .src1_in_rob_o(src1_in_rob_o), .src2_in_rob_o(src2_in_rob_o),
        .src1_tag_o(src1_tag_o), .src2_tag_o(src2_tag_o),
        .issue_valid_o(issue_valid_o), .issue_dst_o(issue_dst_o),
        .issue_rob_tag_o(issue_rob_tag_o), .issue_store_o(issue_store_o),
        .cdb_valid_i(cdb_valid_i), .cdb_rob_tag_i(cdb_rob_tag_i),
        .commit_valid_i(commit_valid_i), .commit_rob_tag_i(commit_rob_tag_i),
        .rob_count_o(rob_count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit exp_ready();
        int fu;
        fu = int'(dec_fu_i);
        return !reset_i && m_drain == 0 && !recover_en && q_tags.size() < 16 &&
               fu < 3 && (((rs_free_i >> fu) & 3'b001) != 3'b000);
    endfunction

    // Returns {wait, in_rob} for one source operand.
    function automatic logic [1:0] exp_src(logic use_b, logic [4:0] a, register_status_s st);
        if (!use_b || a == 5'd0 || !st.busy) return 2'b00;
        if (st.re_busy && !(cdb_valid_i && cdb_rob_tag_i == st.rob_tag)) return 2'b10;
        return 2'b01;
    endfunction

    task automatic model_edge();
        bit fire;
        bit was_drain;
        fire = exp_ready() && dec_valid_i;
        if (reset_i) begin
            q_tags.delete();
            m_tail  = 0;
            m_drain = 0;
            m_err   = 0;
        end else if (recover_en) begin
            q_tags.delete();
            m_tail  = 0;
            m_drain = 2;
        end else begin
            was_drain = (m_drain > 0);
            if (was_drain) m_drain--;
            if (!was_drain && commit_valid_i) begin
                if (q_tags.size() == 0 || q_tags[0] != int'(commit_rob_tag_i)) m_err = 1;
                else void'(q_tags.pop_front());
            end
            if (fire) begin
                q_tags.push_back(m_tail);
                m_tail = (m_tail + 1) % 16;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        recover_en = 0; dec_valid_i = 0; dec_rd_i = 0; dec_rs1_i = 0; dec_rs2_i = 0;
        dec_use_rs1_i = 0; dec_use_rs2_i = 0; dec_fu_i = 0; dec_store_i = 0;
        rs_free_i = 3'b111; packed_rs1_i = '0; packed_rs2_i = '0;
        cdb_valid_i = 0; cdb_rob_tag_i = 0; commit_valid_i = 0; commit_rob_tag_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1;
        tick();
        reset_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i = 1;
        dec_valid_i = 1; dec_rs1_i = 5'd7; dec_use_rs1_i = 1; dec_rd_i = 5'd3;
        packed_rs1_i = {1'b1, 1'b1, 4'd9};
        #1;
        total++;
        if (dec_ready_o !== 0 || issue_valid_o !== 0 || rs1_o !== 0 || src1_wait_o !== 0 ||
            src1_tag_o !== 0 || rs_dispatch_o !== 0 || issue_dst_o !== 0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b valid=%b rs1=%0d wait=%b tag=%0d disp=%b dst=%0d, all required 0",
                     dec_ready_o, issue_valid_o, rs1_o, src1_wait_o, src1_tag_o, rs_dispatch_o, issue_dst_o);
        end
        tick();
        reset_i = 0;
        idle_inputs();
        #1;
        total++;
        if (rob_count_o !== 5'd0 || err_o !== 1'b0 || dec_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL post_reset: count=%0d err=%b ready=%b, required 0 0 1", rob_count_o, err_o, dec_ready_o);
        end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        dec_valid_i = 1; dec_fu_i = 2'd0;
        for (int i = 0; i < 16; i++) begin
            dec_rd_i = 5'(i + 1);
            #1;
            total++;
            if (issue_valid_o !== 1'b1 || issue_rob_tag_o !== 4'(i) || rs_dispatch_o !== 3'b001 ||
                issue_dst_o !== 5'(i + 1)) begin
                bad++;
                $display("FAIL fill_issue%0d: valid=%b tag=%0d disp=%b dst=%0d, required 1 %0d 001 %0d",
                         i, issue_valid_o, issue_rob_tag_o, rs_dispatch_o, issue_dst_o, i, i + 1);
            end
            tick();
        end
        #1;
        total++;
        if (rob_count_o !== 5'd16 || dec_ready_o !== 1'b0 || issue_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL full_stall: count=%0d ready=%b valid=%b, required 16 0 0", rob_count_o, dec_ready_o, issue_valid_o);
        end
        commit_valid_i = 1; commit_rob_tag_i = 4'd0;
        #1;
        total++;
        if (dec_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL full_commit_same_cycle: ready=%b required 0", dec_ready_o);
        end
        tick();
        commit_valid_i = 0;
        #1;
        total++;
        if (dec_ready_o !== 1'b1 || issue_rob_tag_o !== 4'd0 || rob_count_o !== 5'd15) begin
            bad++;
            $display("FAIL wrap_issue: ready=%b tag=%0d count=%0d, required 1 0 15", dec_ready_o, issue_rob_tag_o, rob_count_o);
        end
        tick();
        total++;
        if (rob_count_o !== 5'd16 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL wrap_count: count=%0d err=%b, required 16 0", rob_count_o, err_o);
        end
    endtask

    task automatic test_rs_free();
        do_reset();
        dec_valid_i = 1; dec_fu_i = 2'd1; rs_free_i = 3'b101; dec_store_i = 1;
        #1;
        total++;
        if (dec_ready_o !== 1'b0 || issue_valid_o !== 1'b0 || rs_dispatch_o !== 3'b000) begin
            bad++;
            $display("FAIL lsu_blocked: ready=%b valid=%b disp=%b, required 0 0 000", dec_ready_o, issue_valid_o, rs_dispatch_o);
        end
        rs_free_i = 3'b111;
        #1;
        total++;
        if (issue_valid_o !== 1'b1 || rs_dispatch_o !== 3'b010 || issue_store_o !== 1'b1 || issue_rob_tag_o !== 4'd0) begin
            bad++;
            $display("FAIL lsu_fire: valid=%b disp=%b store=%b tag=%0d, required 1 010 1 0",
                     issue_valid_o, rs_dispatch_o, issue_store_o, issue_rob_tag_o);
        end
        tick();
        dec_fu_i = 2'd3;
        #1;
        total++;
        if (dec_ready_o !== 1'b0 || rob_count_o !== 5'd1) begin
            bad++;
            $display("FAIL bad_fu: ready=%b count=%0d, required 0 1", dec_ready_o, rob_count_o);
        end
    endtask

    task automatic test_commit_with_issue();
        do_reset();
        dec_valid_i = 1; dec_fu_i = 2'd0;
        repeat (5) tick();
        commit_valid_i = 1; commit_rob_tag_i = 4'd0;
        #1;
        total++;
        if (issue_rob_tag_o !== 4'd5 || rob_count_o !== 5'd5) begin
            bad++;
            $display("FAIL count5_issue: tag=%0d count=%0d, required 5 5", issue_rob_tag_o, rob_count_o);
        end
        tick();
        commit_rob_tag_i = 4'd1;
        #1;
        total++;
        if (rob_count_o !== 5'd5 || issue_rob_tag_o !== 4'd6) begin
            bad++;
            $display("FAIL simul_fire_commit: count=%0d tag=%0d, required 5 6", rob_count_o, issue_rob_tag_o);
        end
        tick();
        total++;
        if (err_o !== 1'b0 || rob_count_o !== 5'd5) begin
            bad++;
            $display("FAIL head_advanced: err=%b count=%0d, required 0 5", err_o, rob_count_o);
        end
    endtask

    task automatic test_forward();
        do_reset();
        dec_valid_i = 1; dec_use_rs1_i = 1; dec_rs1_i = 5'd3;
        packed_rs1_i = {1'b1, 1'b1, 4'd7};
        cdb_valid_i = 1; cdb_rob_tag_i = 4'd7;
        #1;
        total++;
        if (src1_wait_o !== 1'b0 || src1_in_rob_o !== 1'b1 || src1_tag_o !== 4'd7 || rs1_o !== 5'd3) begin
            bad++;
            $display("FAIL cdb_forward: wait=%b in_rob=%b tag=%0d rs1=%0d, required 0 1 7 3",
                     src1_wait_o, src1_in_rob_o, src1_tag_o, rs1_o);
        end
        cdb_rob_tag_i = 4'd6;
        #1;
        total++;
        if (src1_wait_o !== 1'b1 || src1_in_rob_o !== 1'b0) begin
            bad++;
            $display("FAIL cdb_miss: wait=%b in_rob=%b, required 1 0", src1_wait_o, src1_in_rob_o);
        end
        dec_rs1_i = 5'd0;
        #1;
        total++;
        if (src1_wait_o !== 1'b0 || src1_in_rob_o !== 1'b0) begin
            bad++;
            $display("FAIL rs1_x0: wait=%b in_rob=%b, required 0 0", src1_wait_o, src1_in_rob_o);
        end
        dec_use_rs2_i = 1; dec_rs2_i = 5'd9; packed_rs2_i = {1'b1, 1'b0, 4'd4};
        #1;
        total++;
        if (src2_wait_o !== 1'b0 || src2_in_rob_o !== 1'b1 || src2_tag_o !== 4'd4 || rs2_o !== 5'd9) begin
            bad++;
            $display("FAIL src2_in_rob: wait=%b in_rob=%b tag=%0d rs2=%0d, required 0 1 4 9",
                     src2_wait_o, src2_in_rob_o, src2_tag_o, rs2_o);
        end
        dec_use_rs2_i = 0;
        #1;
        total++;
        if (src2_wait_o !== 1'b0 || src2_in_rob_o !== 1'b0) begin
            bad++;
            $display("FAIL src2_unused: wait=%b in_rob=%b, required 0 0", src2_wait_o, src2_in_rob_o);
        end
        tick();
    endtask

    task automatic test_recover();
        do_reset();
        dec_valid_i = 1; dec_fu_i = 2'd2;
        repeat (9) tick();
        recover_en = 1;
        #1;
        total++;
        if (rob_count_o !== 5'd9 || dec_ready_o !== 1'b0 || issue_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL recover_cycle: count=%0d ready=%b valid=%b, required 9 0 0", rob_count_o, dec_ready_o, issue_valid_o);
        end
        tick();
        recover_en = 0;
        commit_valid_i = 1; commit_rob_tag_i = 4'd5;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (dec_ready_o !== 1'b0 || rob_count_o !== 5'd0) begin
                bad++;
                $display("FAIL drain%0d: ready=%b count=%0d, required 0 0", i, dec_ready_o, rob_count_o);
            end
            tick();
        end
        commit_valid_i = 0;
        #1;
        total++;
        if (dec_ready_o !== 1'b1 || issue_rob_tag_o !== 4'd0 || rs_dispatch_o !== 3'b100) begin
            bad++;
            $display("FAIL after_drain: ready=%b tag=%0d disp=%b, required 1 0 100", dec_ready_o, issue_rob_tag_o, rs_dispatch_o);
        end
        tick();
        total++;
        if (rob_count_o !== 5'd1 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL recover_count: count=%0d err=%b, required 1 0", rob_count_o, err_o);
        end
    endtask

    task automatic test_err();
        do_reset();
        dec_valid_i = 1;
        repeat (3) tick();
        dec_valid_i = 0; commit_valid_i = 1;
        commit_rob_tag_i = 4'd0; tick();
        commit_rob_tag_i = 4'd1; tick();
        commit_rob_tag_i = 4'd3; tick();
        total++;
        if (err_o !== 1'b1 || rob_count_o !== 5'd1) begin
            bad++;
            $display("FAIL tag_mismatch: err=%b count=%0d, required 1 1", err_o, rob_count_o);
        end
        commit_rob_tag_i = 4'd2; tick();
        total++;
        if (err_o !== 1'b1 || rob_count_o !== 5'd0) begin
            bad++;
            $display("FAIL head_held: err=%b count=%0d, required 1 0", err_o, rob_count_o);
        end
        commit_rob_tag_i = 4'd3; tick();
        total++;
        if (err_o !== 1'b1 || rob_count_o !== 5'd0) begin
            bad++;
            $display("FAIL commit_empty: err=%b count=%0d, required 1 0", err_o, rob_count_o);
        end
        do_reset();
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_cleared: err=%b required 0", err_o);
        end
    endtask

    task automatic test_random();
        bit         e_fire;
        logic [1:0] e_s1, e_s2;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            dec_valid_i   = ($urandom_range(0, 9) < 8);
            dec_fu_i      = 2'($urandom_range(0, 3));
            rs_free_i     = 3'($urandom) | 3'($urandom);
            dec_rd_i      = 5'($urandom); dec_rs1_i = 5'($urandom_range(0, 3));
            dec_rs2_i     = 5'($urandom);
            dec_use_rs1_i = 1'($urandom); dec_use_rs2_i = 1'($urandom);
            dec_store_i   = 1'($urandom);
            packed_rs1_i  = 6'($urandom); packed_rs2_i = 6'($urandom);
            cdb_valid_i   = 1'($urandom); cdb_rob_tag_i = 4'($urandom);
            recover_en    = ($urandom_range(0, 99) < 3);
            commit_valid_i = ($urandom_range(0, 9) < 4);
            if (q_tags.size() > 0 && $urandom_range(0, 19) != 0) commit_rob_tag_i = 4'(q_tags[0]);
            else commit_rob_tag_i = 4'($urandom);
            #1;
            e_fire = exp_ready() && dec_valid_i;
            e_s1   = exp_src(dec_use_rs1_i, dec_rs1_i, packed_rs1_i);
            e_s2   = exp_src(dec_use_rs2_i, dec_rs2_i, packed_rs2_i);
            total++;
            if (dec_ready_o !== exp_ready() || issue_valid_o !== e_fire ||
                rs_dispatch_o !== (e_fire ? 3'(1 << dec_fu_i) : 3'b000) ||
                (e_fire && (issue_rob_tag_o !== 4'(m_tail) || issue_dst_o !== dec_rd_i))) begin
                bad++;
                $display("FAIL rand_issue%0d: ready=%b valid=%b disp=%b tag=%0d, required %b %b tag %0d",
                         n, dec_ready_o, issue_valid_o, rs_dispatch_o, issue_rob_tag_o, exp_ready(), e_fire, m_tail);
            end
            total++;
            if ({src1_wait_o, src1_in_rob_o} !== e_s1 || {src2_wait_o, src2_in_rob_o} !== e_s2) begin
                bad++;
                $display("FAIL rand_src%0d: s1=%b%b s2=%b%b, required %b %b",
                         n, src1_wait_o, src1_in_rob_o, src2_wait_o, src2_in_rob_o, e_s1, e_s2);
            end
            tick();
            total++;
            if (rob_count_o !== 5'(q_tags.size()) || err_o !== m_err) begin
                bad++;
                $display("FAIL rand_state%0d: count=%0d err=%b, required %0d %b", n, rob_count_o, err_o, q_tags.size(), m_err);
            end
        end
    endtask

    initial begin
        q_tags.delete();
        m_tail = 0; m_drain = 0; m_err = 0;
        test_reset();
        test_fill_wrap();
        test_rs_free();
        test_commit_with_issue();
        test_forward();
        test_recover();
        test_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
